// File: rtl/dsi_lane_hs_sequencer.sv
// Single-lane DSI HS burst sequencer: LP-11 -> LP-01 -> LP-00 entry, HS-zero, 0xB8 sync,
// payload pulled from the upstream repacker one byte per cycle, HS trail, then LP-11 exit.
module dsi_lane_hs_sequencer #(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 4,
    parameter int T_HS_TRAIL   = 3,
    parameter int T_HS_EXIT    = 2,
    parameter int MAX_BYTES    = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       src_data_rqst,
    input  logic [7:0] src_input_data,
    input  logic       src_start_rqst,
    input  logic       src_fin_rqst,
    output logic [7:0] hs_data,
    output logic       hs_en,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       err_start_busy,
    output logic       err_overrun
);

    localparam int PH_MAX_A = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
    localparam int PH_MAX_B = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
    localparam int PH_MAX_C = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
    localparam int PH_MAX   = (PH_MAX_C > T_HS_EXIT) ? PH_MAX_C : T_HS_EXIT;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int BC_W     = $clog2(MAX_BYTES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LP01,
        S_LP00,
        S_HSZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic              ovf_q, ovf_d;
    logic              last_b7_q, last_b7_d;
    logic [7:0]        hs_data_q, hs_data_d;
    logic              hs_en_q, hs_en_d;
    logic              lp_p_q, lp_p_d;
    logic              lp_n_q, lp_n_d;
    logic              busy_q, busy_d;
    logic              err_start_busy_q, err_start_busy_d;
    logic              err_overrun_q;
    logic              wdog_hit;

    assign src_data_rqst = (state_q == S_SYNC) || (state_q == S_DATA);
    assign wdog_hit      = !src_fin_rqst && (byte_cnt_q == BC_W'(MAX_BYTES - 1));

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = 1'b0;
        last_b7_d  = last_b7_q;

        if (ph_cnt_q != '0) begin
            ph_cnt_d = ph_cnt_q - PH_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                if (src_start_rqst) begin
                    state_d  = S_LP01;
                    ph_cnt_d = PH_W'(T_LPX - 1);
                end
            end
            S_LP01: begin
                if (ph_cnt_q == '0) begin
                    state_d  = S_LP00;
                    ph_cnt_d = PH_W'(T_HS_PREPARE - 1);
                end
            end
            S_LP00: begin
                if (ph_cnt_q == '0) begin
                    state_d  = S_HSZERO;
                    ph_cnt_d = PH_W'(T_HS_ZERO - 1);
                end
            end
            S_HSZERO: begin
                if (ph_cnt_q == '0) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC, S_DATA: begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                last_b7_d  = src_input_data[7];
                if (src_fin_rqst || wdog_hit) begin
                    // TRAIL's first cycle still shows the last byte, so it runs one extra cycle.
                    state_d  = S_TRAIL;
                    ph_cnt_d = PH_W'(T_HS_TRAIL);
                    ovf_d    = wdog_hit;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TRAIL: begin
                if (ph_cnt_q == '0) begin
                    state_d  = S_EXIT;
                    ph_cnt_d = PH_W'(T_HS_EXIT - 1);
                end
            end
            S_EXIT: begin
                if (ph_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with the state itself.
    always_comb begin
        lp_p_d    = 1'b1;
        lp_n_d    = 1'b1;
        hs_en_d   = 1'b0;
        hs_data_d = 8'h00;

        case (state_d)
            S_LP01: begin
                lp_p_d = 1'b0;
            end
            S_LP00: begin
                lp_p_d = 1'b0;
                lp_n_d = 1'b0;
            end
            S_HSZERO, S_DATA, S_TRAIL: begin
                lp_p_d  = 1'b0;
                lp_n_d  = 1'b0;
                hs_en_d = 1'b1;
            end
            S_SYNC: begin
                lp_p_d    = 1'b0;
                lp_n_d    = 1'b0;
                hs_en_d   = 1'b1;
                hs_data_d = SYNC_BYTE;
            end
            default: begin
                lp_p_d = 1'b1;
            end
        endcase

        if (src_data_rqst) begin
            hs_data_d = src_input_data;
        end else if ((state_q == S_TRAIL) && (state_d == S_TRAIL)) begin
            hs_data_d = {8{~last_b7_q}};
        end

        busy_d           = (state_d != S_IDLE);
        err_start_busy_d = src_start_rqst && (state_q != S_IDLE);
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the
    // sensitivity list; all state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            ph_cnt_q         <= '0;
            byte_cnt_q       <= '0;
            ovf_q            <= 1'b0;
            last_b7_q        <= 1'b0;
            hs_data_q        <= 8'h00;
            hs_en_q          <= 1'b0;
            lp_p_q           <= 1'b1;
            lp_n_q           <= 1'b1;
            busy_q           <= 1'b0;
            err_start_busy_q <= 1'b0;
            err_overrun_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            ph_cnt_q         <= ph_cnt_d;
            byte_cnt_q       <= byte_cnt_d;
            ovf_q            <= ovf_d;
            last_b7_q        <= last_b7_d;
            hs_data_q        <= hs_data_d;
            hs_en_q          <= hs_en_d;
            lp_p_q           <= lp_p_d;
            lp_n_q           <= lp_n_d;
            busy_q           <= busy_d;
            err_start_busy_q <= err_start_busy_d;
            err_overrun_q    <= ovf_q;
        end
    end

    assign hs_data        = hs_data_q;
    assign hs_en          = hs_en_q;
    assign lp_p           = lp_p_q;
    assign lp_n           = lp_n_q;
    assign busy           = busy_q;
    assign err_start_busy = err_start_busy_q;
    assign err_overrun    = err_overrun_q;

endmodule

// File: tb/tb_dsi_lane_hs_sequencer.sv
// Bench for dsi_lane_hs_sequencer: a hand-written vector table for the four-byte burst, then
// directed and random bursts checked against a phase-timeline model of the lane protocol.
module tb_dsi_lane_hs_sequencer;

    localparam int T_LPX   = 2;
    localparam int T_PREP  = 3;
    localparam int T_ZERO  = 4;
    localparam int T_TRAIL = 3;
    localparam int T_EXIT  = 2;
    localparam int MAX_B   = 8;

    logic       clk;
    logic       rst_n;
    logic       src_data_rqst;
    logic [7:0] src_input_data;
    logic       src_start_rqst;
    logic       src_fin_rqst;
    logic [7:0] hs_data;
    logic       hs_en;
    logic       lp_p;
    logic       lp_n;
    logic       busy;
    logic       err_start_busy;
    logic       err_overrun;

    dsi_lane_hs_sequencer #(
        .T_LPX       (T_LPX),
        .T_HS_PREPARE(T_PREP),
        .T_HS_ZERO   (T_ZERO),
        .T_HS_TRAIL  (T_TRAIL),
        .T_HS_EXIT   (T_EXIT),
        .MAX_BYTES   (MAX_B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_data_rqst (src_data_rqst),
        .src_input_data(src_input_data),
        .src_start_rqst(src_start_rqst),
        .src_fin_rqst  (src_fin_rqst),
        .hs_data       (hs_data),
        .hs_en         (hs_en),
        .lp_p          (lp_p),
        .lp_n          (lp_n),
        .busy          (busy),
        .err_start_busy(err_start_busy),
        .err_overrun   (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Table vectors: inputs for one cycle and the outputs expected in that cycle.
    typedef struct {
        logic       start;
        logic [7:0] din;
        logic       fin;
        logic [1:0] lp;
        logic       hs_en;
        logic [7:0] hs_data;
        logic       dchk;
        logic       rqst;
        logic       busy;
    } vec_t;

    function automatic vec_t mk(logic start, logic [7:0] din, logic fin, logic [1:0] lp,
                                logic en, logic [7:0] d, logic dchk, logic rqst, logic bsy);
        vec_t v;
        v.start = start; v.din = din; v.fin = fin; v.lp = lp; v.hs_en = en;
        v.hs_data = d; v.dchk = dchk; v.rqst = rqst; v.busy = bsy;
        return v;
    endfunction

    vec_t vecs[21];

    // Reference-model trace entries.
    typedef struct {
        logic [1:0] lp;
        logic       hs_en;
        logic [7:0] hs_data;
        logic       dchk;
        logic       rqst;
        logic       busy;
        logic       err_sb;
        logic       err_ov;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pay[$];
    int         idx;
    int         fin_pos;
    logic       took;

    function automatic exp_t mk_e(logic [1:0] lp, logic en, logic [7:0] d, logic dchk,
                                  logic rqst, logic bsy);
        exp_t e;
        e.lp = lp; e.hs_en = en; e.hs_data = d; e.dchk = dchk; e.rqst = rqst; e.busy = bsy;
        e.err_sb = 1'b0; e.err_ov = 1'b0;
        return e;
    endfunction

    // Builds the per-cycle expectation from the phase lengths; cycle 0 is the start cycle.
    task automatic build_trace(input int n_sent, input logic ovf, input int es);
        exp_t       e;
        logic       b7;
        exp_q.delete();
        exp_q.push_back(mk_e(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        repeat (T_LPX)  exp_q.push_back(mk_e(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        repeat (T_PREP) exp_q.push_back(mk_e(2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        repeat (T_ZERO) exp_q.push_back(mk_e(2'b00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < n_sent; i++) begin
            exp_q.push_back(mk_e(2'b00, 1'b1, (i == 0) ? 8'hB8 : pay[i-1], 1'b1, 1'b1, 1'b1));
        end
        exp_q.push_back(mk_e(2'b00, 1'b1, pay[n_sent-1], 1'b1, 1'b0, 1'b1));
        b7 = pay[n_sent-1][7];
        for (int i = 0; i < T_TRAIL; i++) begin
            e = mk_e(2'b00, 1'b1, {8{~b7}}, 1'b1, 1'b0, 1'b1);
            e.err_ov = ovf && (i == 0);
            exp_q.push_back(e);
        end
        repeat (T_EXIT) exp_q.push_back(mk_e(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        repeat (4)      exp_q.push_back(mk_e(2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        if (es >= 0 && es + 1 < exp_q.size()) begin
            e = exp_q[es+1];
            e.err_sb = 1'b1;
            exp_q[es+1] = e;
        end
    endtask

    task automatic drive_src();
        src_input_data = (idx < pay.size()) ? pay[idx] : 8'h00;
        src_fin_rqst   = (idx == fin_pos);
    endtask

    // Runs one burst from the current payload; es is the cycle of an extra start (-1: none).
    task automatic run_burst(input string tag, input int fpos, input int es);
        int   n_sent;
        logic ovf;
        exp_t e;
        fin_pos = fpos;
        if (fpos >= 0 && fpos < MAX_B) begin
            n_sent = fpos + 1;
            ovf    = 1'b0;
        end else begin
            n_sent = MAX_B;
            ovf    = 1'b1;
        end
        build_trace(n_sent, ovf, es);
        idx  = 0;
        took = 1'b0;
        for (int t = 0; t < exp_q.size(); t++) begin
            @(posedge clk);
            #1;
            if (took) idx++;
            src_start_rqst = (t == 0) || (t == es);
            drive_src();
            @(negedge clk);
            e = exp_q[t];
            check($sformatf("%s c%0d lp", tag, t), {30'd0, lp_p, lp_n}, {30'd0, e.lp});
            check($sformatf("%s c%0d hs_en", tag, t), {31'd0, hs_en}, {31'd0, e.hs_en});
            if (e.dchk) check($sformatf("%s c%0d hs_data", tag, t), {24'd0, hs_data}, {24'd0, e.hs_data});
            check($sformatf("%s c%0d rqst", tag, t), {31'd0, src_data_rqst}, {31'd0, e.rqst});
            check($sformatf("%s c%0d busy", tag, t), {31'd0, busy}, {31'd0, e.busy});
            check($sformatf("%s c%0d err_start_busy", tag, t), {31'd0, err_start_busy}, {31'd0, e.err_sb});
            check($sformatf("%s c%0d err_overrun", tag, t), {31'd0, err_overrun}, {31'd0, e.err_ov});
            took = src_data_rqst;
        end
        src_start_rqst = 1'b0;
        src_fin_rqst   = 1'b0;
        fin_pos        = -1;
    endtask

    task automatic fill_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        src_start_rqst = 1'b0;
        src_fin_rqst = 1'b0;
        src_input_data = 8'h00;
        idx = 0;
        fin_pos = -1;
        took = 1'b0;

        // Four-byte burst, cycle by cycle: start@0, bytes 11,22,33,84 at 10..13, fin with 84.
        vecs[0]  = mk(1, 8'h00, 0, 2'b11, 0, 8'h00, 1, 0, 0);
        vecs[1]  = mk(0, 8'h00, 0, 2'b01, 0, 8'h00, 0, 0, 1);
        vecs[2]  = mk(0, 8'h00, 0, 2'b01, 0, 8'h00, 0, 0, 1);
        vecs[3]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0, 1);
        vecs[4]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0, 1);
        vecs[5]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0, 1);
        vecs[6]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[7]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[8]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[9]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[10] = mk(0, 8'h11, 0, 2'b00, 1, 8'hB8, 1, 1, 1);
        vecs[11] = mk(0, 8'h22, 0, 2'b00, 1, 8'h11, 1, 1, 1);
        vecs[12] = mk(0, 8'h33, 0, 2'b00, 1, 8'h22, 1, 1, 1);
        vecs[13] = mk(0, 8'h84, 1, 2'b00, 1, 8'h33, 1, 1, 1);
        vecs[14] = mk(0, 8'h00, 0, 2'b00, 1, 8'h84, 1, 0, 1);
        vecs[15] = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[16] = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[17] = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 1, 0, 1);
        vecs[18] = mk(0, 8'h00, 0, 2'b11, 0, 8'h00, 0, 0, 1);
        vecs[19] = mk(0, 8'h00, 0, 2'b11, 0, 8'h00, 0, 0, 1);
        vecs[20] = mk(0, 8'h00, 0, 2'b11, 0, 8'h00, 0, 0, 0);

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset lp", {30'd0, lp_p, lp_n}, 32'd3);
        check("reset hs_en", {31'd0, hs_en}, 32'd0);
        check("reset hs_data", {24'd0, hs_data}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rqst", {31'd0, src_data_rqst}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int t = 0; t < 21; t++) begin
            @(posedge clk);
            #1;
            src_start_rqst = vecs[t].start;
            src_input_data = vecs[t].din;
            src_fin_rqst   = vecs[t].fin;
            @(negedge clk);
            check($sformatf("tbl c%0d lp", t), {30'd0, lp_p, lp_n}, {30'd0, vecs[t].lp});
            check($sformatf("tbl c%0d hs_en", t), {31'd0, hs_en}, {31'd0, vecs[t].hs_en});
            if (vecs[t].dchk) check($sformatf("tbl c%0d hs_data", t), {24'd0, hs_data}, {24'd0, vecs[t].hs_data});
            check($sformatf("tbl c%0d rqst", t), {31'd0, src_data_rqst}, {31'd0, vecs[t].rqst});
            check($sformatf("tbl c%0d busy", t), {31'd0, busy}, {31'd0, vecs[t].busy});
        end
        src_start_rqst = 1'b0;
        src_fin_rqst   = 1'b0;
        src_input_data = 8'h00;
        repeat (2) @(posedge clk);

        // One-byte burst: fin with 0x7F in the SYNC cycle, trail of 0xFF.
        pay.delete();
        pay.push_back(8'h7F);
        run_burst("one_byte", 0, -1);

        // Second start during HSZERO is flagged and otherwise ignored.
        fill_pay(4);
        run_burst("busy_start", 3, 7);

        // Ten bytes offered, no fin: the watchdog stops at MAX_B requests.
        fill_pay(10);
        run_burst("watchdog", -1, -1);

        // Reset asserted while in DATA.
        fill_pay(12);
        fin_pos = -1;
        idx = 0;
        took = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            @(posedge clk);
            #1;
            if (took) idx++;
            src_start_rqst = (t == 0);
            drive_src();
            if (t == 12) rst_n = 1'b0;
            @(negedge clk);
            took = src_data_rqst;
        end
        check("midrst before rqst", {31'd0, src_data_rqst}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        src_input_data = 8'h00;
        src_fin_rqst = 1'b0;
        @(negedge clk);
        check("midrst lp", {30'd0, lp_p, lp_n}, 32'd3);
        check("midrst hs_en", {31'd0, hs_en}, 32'd0);
        check("midrst rqst", {31'd0, src_data_rqst}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        fill_pay(5);
        run_burst("post_rst", 4, -1);

        // Random bursts: length, fin position, payload and stray starts all drawn at random.
        for (int n = 0; n < 25; n++) begin
            int fp;
            int es;
            fill_pay(12);
            fp = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 11)) : -1;
            es = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 16)) : -1;
            run_burst($sformatf("rnd%0d", n), fp, es);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
